// File: rtl/color_playback_sequencer_if.sv
// Pattern write, playback handshake and LED/tone outputs of the Simon
// playback sequencer. master = game FSM side, slave = sequencer side.
interface color_playback_sequencer_if;
  logic       wr_en;
  logic [2:0] wr_addr;
  logic [1:0] wr_color;
  logic       start;
  logic [2:0] last_index;
  logic [2:0] level;
  logic       abort;
  logic       busy;
  logic       done;
  logic [2:0] index;
  logic [2:0] note;
  logic       LED16_R;
  logic       LED16_G;
  logic       LED16_B;

  modport master (
    output wr_en, wr_addr, wr_color,
    output start, last_index, level, abort,
    input  busy, done, index, note,
    input  LED16_R, LED16_G, LED16_B
  );

  modport slave (
    input  wr_en, wr_addr, wr_color,
    input  start, last_index, level, abort,
    output busy, done, index, note,
    output LED16_R, LED16_G, LED16_B
  );
endinterface

// File: rtl/color_playback_sequencer.sv
// Plays pattern entries 0..last_index on the RGB LED and tone code,
// one on/off period per entry; period shrinks with level.
// Ports: CLK, RST (sync, active high), bus (slave modport): pattern
// write (wr_*), start/last_index/level/abort in; busy/done/index,
// note, LED16_R/G/B out. All outputs are registered.
module color_playback_sequencer #(
  parameter int unsigned DEPTH       = 8,
  parameter int unsigned BASE_PERIOD = 100000000,
  parameter int unsigned STEP        = 13333333,
  parameter int unsigned MIN_PERIOD  = 20000000
) (
  input logic                         CLK,
  input logic                         RST,
  color_playback_sequencer_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ON,
    S_OFF,
    S_DONE
  } state_e;

  localparam logic [2:0] NOTE_SIL = 3'd5;

  state_e      state_q, state_d;
  logic [1:0]  mem_q [DEPTH];
  logic [1:0]  mem_d [DEPTH];
  logic [31:0] timer_q, timer_d;
  logic [31:0] half_q, half_d;
  logic [31:0] off_q, off_d;
  logic [2:0]  last_q, last_d;
  logic [2:0]  idx_q, idx_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [2:0]  note_q, note_d;
  logic [2:0]  rgb_q, rgb_d;

  logic [31:0] prod;
  logic [31:0] per;

  // {R,G,B,note} for a stored color
  function automatic logic [5:0] decode(input logic [1:0] c);
    logic [5:0] r;
    unique case (c)
      2'd0: r = {3'b100, 3'd0};
      2'd1: r = {3'b010, 3'd1};
      2'd2: r = {3'b001, 3'd2};
      2'd3: r = {3'b110, 3'd3};
    endcase
    return r;
  endfunction

  // Underflow and floor both clamp to MIN_PERIOD
  always_comb begin
    prod = 32'(bus.level) * STEP;
    if (prod > BASE_PERIOD ||
        (BASE_PERIOD - prod) < MIN_PERIOD)
      per = MIN_PERIOD;
    else
      per = BASE_PERIOD - prod;
  end

  always_comb begin
    state_d = state_q;
    mem_d   = mem_q;
    timer_d = timer_q;
    half_d  = half_q;
    off_d   = off_q;
    last_d  = last_q;
    idx_d   = idx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    note_d  = note_q;
    rgb_d   = rgb_q;

    // Latches below read mem_q, so a same-edge write is not seen
    if (bus.wr_en)
      mem_d[bus.wr_addr] = bus.wr_color;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.abort) begin
          state_d         = S_ON;
          idx_d           = 3'd0;
          timer_d         = 32'd0;
          half_d          = per >> 1;
          off_d           = per - (per >> 1);
          last_d          = bus.last_index;
          busy_d          = 1'b1;
          {rgb_d, note_d} = decode(mem_q[0]);
        end
      end
      S_ON: begin
        if (timer_q == half_q - 32'd1) begin
          state_d = S_OFF;
          timer_d = 32'd0;
          rgb_d   = 3'b000;
          note_d  = NOTE_SIL;
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end
      S_OFF: begin
        if (timer_q == off_q - 32'd1) begin
          timer_d = 32'd0;
          if (idx_q == last_q) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            state_d         = S_ON;
            idx_d           = idx_q + 3'd1;
            {rgb_d, note_d} = decode(mem_q[idx_q + 3'd1]);
          end
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        idx_d   = 3'd0;
      end
    endcase

    if (bus.abort && state_q != S_IDLE) begin
      state_d = S_IDLE;
      timer_d = 32'd0;
      idx_d   = 3'd0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      rgb_d   = 3'b000;
      note_d  = NOTE_SIL;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      for (int i = 0; i < DEPTH; i++)
        mem_q[i] <= 2'd0;
      timer_q <= 32'd0;
      half_q  <= 32'd0;
      off_q   <= 32'd0;
      last_q  <= 3'd0;
      idx_q   <= 3'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      note_q  <= NOTE_SIL;
      rgb_q   <= 3'b000;
    end else begin
      state_q <= state_d;
      mem_q   <= mem_d;
      timer_q <= timer_d;
      half_q  <= half_d;
      off_q   <= off_d;
      last_q  <= last_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      note_q  <= note_d;
      rgb_q   <= rgb_d;
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.index   = idx_q;
  assign bus.note    = note_q;
  assign bus.LED16_R = rgb_q[2];
  assign bus.LED16_G = rgb_q[1];
  assign bus.LED16_B = rgb_q[0];

endmodule

// File: tb/tb_color_playback_sequencer.sv
// Bench for color_playback_sequencer: directed scenarios plus random
// traffic against a queue-based per-cycle expectation model.
module tb_color_playback_sequencer;

  localparam int BASE = 20;
  localparam int STP  = 4;
  localparam int MINP = 8;

  localparam int K_ON   = 0;
  localparam int K_OFF  = 1;
  localparam int K_DONE = 2;

  typedef struct {
    int kind;
    int idx;
    bit first;
  } item_t;

  logic CLK;
  logic RST;

  color_playback_sequencer_if bus ();

  color_playback_sequencer #(
    .DEPTH       (8),
    .BASE_PERIOD (BASE),
    .STEP        (STP),
    .MIN_PERIOD  (MINP)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int n_chk  = 0;
  int n_fail = 0;

  int    mem_m [8];
  item_t q [$];
  int    m_color;
  logic  m_busy, m_done;
  logic [2:0] m_idx, m_note, m_rgb;

  int busy_cnt, done_cnt;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               tag, obs, exp, $time);
    end
  endtask

  function automatic logic [2:0] rgb_of(input int c);
    case (c)
      0:       return 3'b100;
      1:       return 3'b010;
      2:       return 3'b001;
      default: return 3'b110;
    endcase
  endfunction

  task automatic m_idle();
    m_busy = 0;
    m_done = 0;
    m_idx  = 0;
    m_note = 3'd5;
    m_rgb  = 3'b000;
  endtask

  task automatic m_pop();
    item_t it;
    it = q.pop_front();
    m_idx = 3'(it.idx);
    if (it.kind == K_ON) begin
      if (it.first) m_color = mem_m[it.idx];
      m_busy = 1;
      m_done = 0;
      m_rgb  = rgb_of(m_color);
      m_note = 3'(m_color);
    end else if (it.kind == K_OFF) begin
      m_busy = 1;
      m_done = 0;
      m_rgb  = 3'b000;
      m_note = 3'd5;
    end else begin
      m_busy = 0;
      m_done = 1;
      m_rgb  = 3'b000;
      m_note = 3'd5;
    end
  endtask

  task automatic m_build();
    longint p;
    int on_n, off_n;
    p = longint'(BASE) - longint'(bus.level) * STP;
    if (p < MINP) p = MINP;
    on_n  = int'(p / 2);
    off_n = int'(p) - on_n;
    for (int i = 0; i <= int'(bus.last_index); i++) begin
      for (int c = 0; c < on_n; c++)
        q.push_back('{K_ON, i, c == 0});
      for (int c = 0; c < off_n; c++)
        q.push_back('{K_OFF, i, 1'b0});
    end
    q.push_back('{K_DONE, 0, 1'b0});
  endtask

  // Expected outputs after the coming edge, from the inputs now applied
  task automatic m_step();
    if (RST) begin
      q.delete();
      m_idle();
      foreach (mem_m[i]) mem_m[i] = 0;
      return;
    end
    if ((m_busy || m_done) && bus.abort) begin
      q.delete();
      m_idle();
    end else if (q.size() > 0) begin
      m_pop();
    end else if (!m_done && bus.start && !bus.abort) begin
      m_build();
      m_pop();
    end else begin
      m_idle();
    end
    if (bus.wr_en) mem_m[bus.wr_addr] = int'(bus.wr_color);
  endtask

  task automatic tick();
    m_step();
    @(posedge CLK);
    @(negedge CLK);
    if (bus.busy === 1'b1) busy_cnt++;
    if (bus.done === 1'b1) done_cnt++;
    chk("busy", 32'(bus.busy), 32'(m_busy));
    chk("done", 32'(bus.done), 32'(m_done));
    chk("note", 32'(bus.note), 32'(m_note));
    chk("rgb",
        32'({bus.LED16_R, bus.LED16_G, bus.LED16_B}),
        32'(m_rgb));
    if (m_busy) chk("index", 32'(bus.index), 32'(m_idx));
  endtask

  task automatic wr(input int a, input int c);
    bus.wr_en    = 1'b1;
    bus.wr_addr  = 3'(a);
    bus.wr_color = 2'(c);
    tick();
    bus.wr_en    = 1'b0;
  endtask

  task automatic play(input int last, input int lvl, input int n);
    bus.start      = 1'b1;
    bus.last_index = 3'(last);
    bus.level      = 3'(lvl);
    tick();
    bus.start      = 1'b0;
    repeat (n) tick();
  endtask

  initial begin
    RST            = 1'b1;
    bus.wr_en      = 1'b0;
    bus.wr_addr    = 3'd0;
    bus.wr_color   = 2'd0;
    bus.start      = 1'b0;
    bus.last_index = 3'd0;
    bus.level      = 3'd0;
    bus.abort      = 1'b0;
    m_color        = 0;
    m_idle();
    repeat (2) tick();
    RST = 1'b0;
    tick();

    for (int i = 0; i < 4; i++) wr(i, i);

    busy_cnt = 0;
    done_cnt = 0;
    play(3, 0, 90);
    chk("busy_len_l0", 32'(busy_cnt), 32'd80);
    chk("done_cnt_l0", 32'(done_cnt), 32'd1);

    busy_cnt = 0;
    play(3, 2, 55);
    chk("busy_len_l2", 32'(busy_cnt), 32'd48);

    busy_cnt = 0;
    play(3, 7, 40);
    chk("busy_len_l7", 32'(busy_cnt), 32'd32);

    wr(0, 3);
    busy_cnt = 0;
    done_cnt = 0;
    play(0, 0, 25);
    chk("busy_len_y", 32'(busy_cnt), 32'd20);
    chk("done_cnt_y", 32'(done_cnt), 32'd1);

    wr(0, 0);
    done_cnt = 0;
    play(3, 0, 24);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    repeat (5) tick();
    chk("abort_nodone", 32'(done_cnt), 32'd0);
    play(3, 0, 3);
    chk("replay_idx", 32'(bus.index), 32'd0);
    repeat (85) tick();

    bus.start = 1'b1;
    bus.level = 3'd0;
    repeat (30) tick();
    bus.start = 1'b0;
    repeat (60) tick();

    bus.start = 1'b1;
    bus.abort = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.abort = 1'b0;
    chk("start_abort", 32'(bus.busy), 32'd0);
    repeat (3) tick();

    play(3, 0, 15);
    RST = 1'b1;
    tick();
    RST = 1'b0;
    play(0, 0, 0);
    chk("red_after_rst",
        32'({bus.LED16_R, bus.LED16_G, bus.LED16_B}),
        32'd4);
    repeat (25) tick();

    for (int n = 0; n < 4000; n++) begin
      bus.wr_en      = ($urandom % 4) == 0;
      bus.wr_addr    = 3'($urandom);
      bus.wr_color   = 2'($urandom);
      bus.start      = ($urandom % 16) == 0;
      bus.last_index = 3'($urandom);
      bus.level      = 3'($urandom);
      bus.abort      = ($urandom % 150) == 0;
      RST            = ($urandom % 1000) == 0;
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
